// File: rtl/nibble_pack.sv
// nibble_pack: packs four serial nibbles into a 16-bit word with a valid/ready handshake.
// Define NIBBLE_PACK_FLUSH_EN to add the flush port that pads and closes a partial word.
module nibble_pack #(
    parameter logic [3:0] PAD_NIBBLE = 4'hF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_data,
`ifdef NIBBLE_PACK_FLUSH_EN
    input  logic        flush,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_cnt
);
    typedef enum logic {FILL, FULL} state_t;
    state_t state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [15:0] data_n;
    logic [2:0] ocnt_n;
`ifdef NIBBLE_PACK_FLUSH_EN
    logic [2:0] real_n;
`endif
    // While full, a new nibble is taken only in the cycle the word leaves
    assign in_ready = (state == FILL) | out_ready;
    assign out_valid = (state == FULL);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= FILL;
            cnt <= 2'd0;
            out_data <= 16'h0000;
            out_cnt <= 3'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            out_data <= data_n;
            out_cnt <= ocnt_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        data_n = out_data;
        ocnt_n = out_cnt;
`ifdef NIBBLE_PACK_FLUSH_EN
        real_n = {1'b0, cnt} + {2'b00, in_valid};
`endif
        if (state == FILL) begin
            if (in_valid) begin
                data_n[{cnt, 2'b00} +: 4] = in_data;
                cnt_n = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_n = FULL;
                    ocnt_n = 3'd4;
                end
            end
`ifdef NIBBLE_PACK_FLUSH_EN
            // A nibble arriving with flush lands first; a 4th nibble is a normal close
            if (flush && real_n != 3'd0 && real_n != 3'd4) begin
                for (int k = 0; k < 4; k++)
                    if (3'(k) >= real_n) data_n[4*k +: 4] = PAD_NIBBLE;
                ocnt_n = real_n;
                cnt_n = 2'd0;
                state_n = FULL;
            end
`endif
        end else if (out_ready) begin
            state_n = FILL;
            cnt_n = {1'b0, in_valid};
            if (in_valid) data_n[3:0] = in_data;
        end
    end
endmodule

// File: tb/tb_nibble_pack.sv
// tb_nibble_pack: directed vectors with a queued scoreboard checked by an output monitor.
module tb_nibble_pack;
    typedef struct {
        logic [15:0] data;
        logic [2:0]  cnt;
    } word_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [3:0] in_data = 4'h0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [15:0] out_data;
    logic [2:0] out_cnt;
`ifdef NIBBLE_PACK_FLUSH_EN
    logic flush = 1'b0;
`endif
    word_t q[$];
    int checks = 0;
    int errs = 0;

    nibble_pack dut (
        .clk(clk),
        .nrst(nrst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef NIBBLE_PACK_FLUSH_EN
        .flush(flush),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [15:0] d, input logic [2:0] c);
        word_t w;
        w.data = d;
        w.cnt = c;
        q.push_back(w);
    endtask

    task automatic send(input logic [3:0] n);
        int i;
        in_valid = 1'b1;
        in_data = n;
        for (i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        if (i == 50) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
            else begin
                word_t w;
                w = q.pop_front();
                chk("word_data", {16'h0, out_data}, {16'h0, w.data});
                chk("word_cnt", {29'h0, out_cnt}, {29'h0, w.cnt});
            end
        end
    end

    initial begin
        #3;
        chk("rst_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_data", {16'h0, out_data}, 32'h0);
        chk("rst_cnt", {29'h0, out_cnt}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        // 3,1,4,2 held downstream, then stall with a pending nibble
        out_ready = 1'b0;
        expect_word(16'h2413, 3'd4);
        send(4'h3);
        send(4'h1);
        send(4'h4);
        send(4'h2);
        chk("latency_valid", {31'h0, out_valid}, 32'd1);
        in_valid = 1'b1;
        in_data = 4'h9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
            chk("stall_hold", {16'h0, out_data}, 32'h2413);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("after_xfer_valid", {31'h0, out_valid}, 32'd0);
        chk("pending_slot0", {28'h0, out_data[3:0]}, 32'h9);
        expect_word(16'h6789, 3'd4);
        send(4'h8);
        send(4'h7);
        send(4'h6);
        // Continuous stream 0..F
        expect_word(16'h3210, 3'd4);
        expect_word(16'h7654, 3'd4);
        expect_word(16'hBA98, 3'd4);
        expect_word(16'hFEDC, 3'd4);
        for (int n = 0; n < 16; n++) send(4'(n));
        @(posedge clk);
        #1;
        // Reset mid-word discards content
        send(4'hA);
        send(4'h5);
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_data", {16'h0, out_data}, 32'h0);
        chk("midrst_valid", {31'h0, out_valid}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        expect_word(16'h4321, 3'd4);
        send(4'h1);
        send(4'h2);
        send(4'h3);
        send(4'h4);
        @(posedge clk);
        #1;
`ifdef NIBBLE_PACK_FLUSH_EN
        expect_word(16'hFF97, 3'd2);
        send(4'h7);
        send(4'h9);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        expect_word(16'hF697, 3'd3);
        send(4'h7);
        send(4'h9);
        flush = 1'b1;
        send(4'h6);
        flush = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_empty_ignored", {31'h0, out_valid}, 32'd0);
        expect_word(16'h8765, 3'd4);
        send(4'h5);
        send(4'h6);
        send(4'h7);
        flush = 1'b1;
        send(4'h8);
        flush = 1'b0;
`endif
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
